serial_frame_tx: RTL

Upstream serializer for the 48-bit serial-to-parallel expander stage. It accepts a parallel word over a valid/ready handshake and drives the three-wire link: sclk_o, ncs_o and sdat_o, MSB first. The downstream stage shifts on each sclk rising edge while ncs is low, then latches on the ncs rising edge. sclk is derived from the system clock by a half-period divider, and a guaranteed ncs-high gap separates frames.

---
 rtl/serial_link_pkg.sv | 21 ++
 rtl/half_period_timer.sv | 31 +++
 rtl/serial_frame_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial frame link: FSM states, default frame width
// and a counter-width helper.
package serial_link_pkg;

  localparam int DEFAULT_WIDTH = 48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Restartable divider: tick_o is high on every DIV-th enabled cycle, and the
// count returns to zero whenever en_i is low.
module half_period_timer
  import serial_link_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serializes one parallel word per valid/ready handshake onto the sclk/ncs/sdat
// link, MSB first, with an enforced ncs-high gap between frames.
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sclk_o,
  output logic             ncs_o,
  output logic             sdat_o,
  output logic             busy_o,
  output logic             done_o,
  output state_t           dbg_state
);

  if (DIV < 1 || GAP < 1 || WIDTH < 2) begin : g_param_check
    $error("serial_frame_tx: requires DIV >= 1, GAP >= 1 and WIDTH >= 2");
  end

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);

  // Handshake: a word transfers on a clk_i edge where valid_i && ready_o;
  // data_i is sampled only then, and valid_i is ignored while ready_o is low.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             sclk_q, sclk_d;
  logic             ncs_q, ncs_d;
  logic             sdat_q, sdat_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  half_period_timer #(.DIV(DIV)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != S_IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      sclk_q   <= 1'b0;
      ncs_q    <= 1'b1;
      sdat_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      sclk_q   <= sclk_d;
      ncs_q    <= ncs_d;
      sdat_q   <= sdat_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    sclk_d   = sclk_q;
    ncs_d    = ncs_q;
    sdat_d   = sdat_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          shreg_d  = data_i;
          sdat_d   = data_i[WIDTH-1];
          ncs_d    = 1'b0;
          sclk_d   = 1'b0;
          bitcnt_d = '0;
          gapcnt_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        // Data only moves on the falling edge, so it is stable a full
        // half-period either side of every rising edge.
        if (tick) begin
          sclk_d = 1'b0;
          if (bitcnt_q == LAST_BIT) begin
            state_d = S_HOLD;
          end else begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            sdat_d   = shreg_q[WIDTH-2];
            bitcnt_d = bitcnt_q + BW'(1);
            state_d  = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gapcnt_q == LAST_GAP) begin
            gapcnt_d = '0;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            gapcnt_d = gapcnt_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o   = ready_q;
  assign sclk_o    = sclk_q;
  assign ncs_o     = ncs_q;
  assign sdat_o    = sdat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign dbg_state = state_q;

endmodule
